zenith_soc: RTL and testbench
=============================

ZENITH_SOC -- requirements
Module: zenith_soc

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- GPIO_DEVICE_NUMBER, 1, GPIO slots.
- UART_DEVICE_NUMBER, 1, UART slots.
- SPI_DEVICE_NUMBER, 1, SPI slots.
- USER_MEMORY_REGION_START, 32'h0010_0000, first DDR address.
- LOCK_CYCLES, 16, cycles from reset release to locked_o.
REQ-002 SHALL derive DEVICES = GPIO+UART+SPI counts; device slots, in order: GPIO slots, then UART slots, then SPI slots (default UART slot = 1).
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk_i  in  1  sole clock, rising edge.
- rst_n_i  in  1  reset, synchronous, active-high; name kept per codebase.
- locked_o  out  1  system ready.
- cpu_load_request_i / cpu_load_address_i / cpu_load_invalidate_i  in  1/32/1  CPU load channel.
- cpu_load_data_o / cpu_load_valid_o  out  32/1  load response.
- cpu_store_request_i / cpu_store_address_i / cpu_store_data_i  in  1/32/32  CPU store channel.
- cpu_store_done_o  out  1  store complete.
- ddr_load_request_o / ddr_load_address_o / ddr_load_invalidate_o  out  1/32/1  DDR load channel.
- ddr_load_data_i / ddr_load_valid_i  in  32/1  DDR load response.
- ddr_store_request_o / ddr_store_address_o / ddr_store_data_o  out  1/32/32  DDR store channel.
- ddr_store_done_i  in  1  DDR store complete.
- write_request_o / write_address_o / write_data_o  out  DEVICES / DEVICES x6 / DEVICES x32  per-device register write.
- write_done_i  in  DEVICES  per-device write ack.
- read_request_o / read_address_o  out  DEVICES / DEVICES x6  per-device register read.
- read_data_i / read_valid_i  in  DEVICES x32 / DEVICES  per-device read response.

Function
REQ-004 SHALL decode address < USER_MEMORY_REGION_START as IO, otherwise DDR.
REQ-005 IO decode SHALL be: slot = address[12:8], register word index = address[7:2]; bits [1:0] and [31:13] are ignored in the IO region.
REQ-006 All *_request_o outputs SHALL be registered single-cycle pulses, asserted the cycle after the accepted CPU request, with address/data held stable until completion.
REQ-007 The load path SHALL allow one outstanding load; a cpu_load_request_i while a load is pending SHALL be ignored. The same rule SHALL apply independently to the store path.
REQ-008 On a load response (read_valid_i of the addressed slot, or ddr_load_valid_i), the block SHALL drive cpu_load_valid_o high for exactly one cycle on the following cycle, with registered data.
REQ-009 On a store ack (write_done_i of the addressed slot, or ddr_store_done_i), the block SHALL pulse cpu_store_done_o for one cycle on the following cycle.
REQ-010 Responses from non-addressed slots SHALL be ignored.
REQ-011 cpu_load_invalidate_i SHALL cancel the pending load: no cpu_load_valid_o for that load, even if the response arrives in the same cycle.
REQ-012 If the cancelled load targets DDR, the block SHALL pulse ddr_load_invalidate_o the next cycle.
REQ-013 Invalidate with no load pending SHALL have no effect.
REQ-014 An IO slot >= DEVICES SHALL produce no device request. A store to it SHALL get cpu_store_done_o 1 cycle after the request; a load from it SHALL get cpu_load_valid_o 1 cycle after the request with data 0.
REQ-015 A simultaneous load and store SHALL both be accepted; the channels are independent, including to the same slot.
REQ-016 locked_o SHALL rise exactly LOCK_CYCLES cycles after rst_n_i deasserts and stay high until the next reset. CPU requests SHALL be ignored while locked_o is low.
REQ-017 Control state per channel SHALL be: IDLE -> PENDING on accept; PENDING -> RESPOND on ack; RESPOND -> IDLE after the one-cycle pulse; PENDING -> IDLE on invalidate.

Reset
REQ-018 While rst_n_i is high, all outputs SHALL be 0, both channels SHALL return to IDLE, and the lock counter SHALL clear.
REQ-019 A reset asserted mid-transaction SHALL abort the transaction without any completion pulse; late acks arriving after reset SHALL be ignored.

Verification
REQ-020 Reset high 40 cycles, then low -> locked_o=0 for 15 cycles, locked_o=1 on cycle 16.
REQ-021 Store 0x41 to 0x0000_0104 -> write_request_o[1]=1 one cycle later with write_address_o[1]=1 and write_data_o[1]=0x41; write_done_i[1] -> cpu_store_done_o pulses one cycle later.
REQ-022 Load 0x0010_0040 -> ddr_load_request_o with address 0x0010_0040; ddr_load_valid_i with data 0xDEADBEEF -> cpu_load_valid_o with 0xDEADBEEF one cycle later.
REQ-023 DDR load pending, then invalidate in the same cycle as ddr_load_valid_i -> no cpu_load_valid_o, and ddr_load_invalidate_o pulses once.
REQ-024 Load 0x0000_1F00 (slot 31) -> no read_request_o; cpu_load_valid_o=1 with data 0 one cycle later.
REQ-025 Second load request issued while the first is pending -> ignored; exactly one device read_request_o and one cpu_load_valid_o.

Source files
------------

// File: rtl/zenith_soc.sv
// CPU-side bus bridge: decodes CPU load/store requests into per-device register
// accesses (IO region) or DDR accesses, with one outstanding transaction per channel.
module zenith_soc #(
   parameter int          GPIO_DEVICE_NUMBER       = 1,
   parameter int          UART_DEVICE_NUMBER       = 1,
   parameter int          SPI_DEVICE_NUMBER        = 1,
   parameter logic [31:0] USER_MEMORY_REGION_START = 32'h0010_0000,
   parameter int          LOCK_CYCLES              = 16,
   localparam int         DEVICES = GPIO_DEVICE_NUMBER + UART_DEVICE_NUMBER + SPI_DEVICE_NUMBER
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   output logic                       locked_o,
   input  logic                       cpu_load_request_i,
   input  logic [31:0]                cpu_load_address_i,
   input  logic                       cpu_load_invalidate_i,
   output logic [31:0]                cpu_load_data_o,
   output logic                       cpu_load_valid_o,
   input  logic                       cpu_store_request_i,
   input  logic [31:0]                cpu_store_address_i,
   input  logic [31:0]                cpu_store_data_i,
   output logic                       cpu_store_done_o,
   output logic                       ddr_load_request_o,
   output logic [31:0]                ddr_load_address_o,
   output logic                       ddr_load_invalidate_o,
   input  logic [31:0]                ddr_load_data_i,
   input  logic                       ddr_load_valid_i,
   output logic                       ddr_store_request_o,
   output logic [31:0]                ddr_store_address_o,
   output logic [31:0]                ddr_store_data_o,
   input  logic                       ddr_store_done_i,
   output logic [DEVICES-1:0]         write_request_o,
   output logic [DEVICES-1:0][5:0]    write_address_o,
   output logic [DEVICES-1:0][31:0]   write_data_o,
   input  logic [DEVICES-1:0]         write_done_i,
   output logic [DEVICES-1:0]         read_request_o,
   output logic [DEVICES-1:0][5:0]    read_address_o,
   input  logic [DEVICES-1:0][31:0]   read_data_i,
   input  logic [DEVICES-1:0]         read_valid_i
);

   typedef enum logic [1:0] {S_IDLE, S_PENDING, S_RESPOND} state_t;

   localparam int LW = $clog2(LOCK_CYCLES + 1);

   logic [LW-1:0]      r_lock_cnt;
   logic               r_locked;

   state_t             r_ld_state, w_ld_next;
   logic               r_ld_ddr;
   logic [4:0]         r_ld_slot;
   logic [5:0]         r_ld_word;
   logic [31:0]        r_ld_data;
   logic [31:0]        r_ddr_ld_addr;
   logic               r_ddr_ld_req;
   logic               r_ddr_ld_inv;
   logic [DEVICES-1:0] r_rd_req;

   state_t             r_st_state, w_st_next;
   logic               r_st_ddr;
   logic [4:0]         r_st_slot;
   logic [5:0]         r_st_word;
   logic [31:0]        r_st_data;
   logic [31:0]        r_ddr_st_addr;
   logic               r_ddr_st_req;
   logic [DEVICES-1:0] r_wr_req;

   logic               w_ld_io, w_ld_slot_ok, w_ld_accept, w_ld_ack, w_ld_io_ack, w_ld_cancel;
   logic [4:0]         w_ld_slot;
   logic [31:0]        w_ld_io_data;
   logic               w_st_io, w_st_slot_ok, w_st_accept, w_st_ack, w_st_io_ack;
   logic [4:0]         w_st_slot;

   // Lock counter: locked rises on the LOCK_CYCLES-th edge after reset release
   always_ff @(posedge clk_i) begin
      if (rst_n_i) begin
         r_lock_cnt <= '0;
         r_locked   <= 1'b0;
      end else if (!r_locked) begin
         if (r_lock_cnt == LW'(LOCK_CYCLES - 1)) r_locked <= 1'b1;
         r_lock_cnt <= r_lock_cnt + 1'b1;
      end
   end

   assign w_ld_io      = cpu_load_address_i < USER_MEMORY_REGION_START;
   assign w_ld_slot    = cpu_load_address_i[12:8];
   assign w_ld_slot_ok = {1'b0, w_ld_slot} < 6'(DEVICES);
   assign w_ld_accept  = r_locked && (r_ld_state == S_IDLE) && cpu_load_request_i;
   assign w_st_io      = cpu_store_address_i < USER_MEMORY_REGION_START;
   assign w_st_slot    = cpu_store_address_i[12:8];
   assign w_st_slot_ok = {1'b0, w_st_slot} < 6'(DEVICES);
   assign w_st_accept  = r_locked && (r_st_state == S_IDLE) && cpu_store_request_i;

   always_ff @(posedge clk_i) begin
      if (rst_n_i) begin
         r_ld_state <= S_IDLE;
         r_st_state <= S_IDLE;
      end else begin
         r_ld_state <= w_ld_next;
         r_st_state <= w_st_next;
      end
   end

   // Load channel next state; invalidate beats a same-cycle response
   always_comb begin
      w_ld_next    = r_ld_state;
      w_ld_io_ack  = 1'b0;
      w_ld_io_data = '0;
      for (int d = 0; d < DEVICES; d++) begin
         if (r_ld_slot == 5'(d)) begin
            w_ld_io_ack  = read_valid_i[d];
            w_ld_io_data = read_data_i[d];
         end
      end
      w_ld_ack    = r_ld_ddr ? ddr_load_valid_i : w_ld_io_ack;
      w_ld_cancel = (r_ld_state == S_PENDING) && cpu_load_invalidate_i;
      case (r_ld_state)
         S_IDLE:    if (w_ld_accept) w_ld_next = (w_ld_io && !w_ld_slot_ok) ? S_RESPOND : S_PENDING;
         S_PENDING: if (cpu_load_invalidate_i) w_ld_next = S_IDLE;
                    else if (w_ld_ack)     w_ld_next = S_RESPOND;
         default:   w_ld_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_st_next   = r_st_state;
      w_st_io_ack = 1'b0;
      for (int d = 0; d < DEVICES; d++) begin
         if (r_st_slot == 5'(d)) w_st_io_ack = write_done_i[d];
      end
      w_st_ack = r_st_ddr ? ddr_store_done_i : w_st_io_ack;
      case (r_st_state)
         S_IDLE:    if (w_st_accept) w_st_next = (w_st_io && !w_st_slot_ok) ? S_RESPOND : S_PENDING;
         S_PENDING: if (w_st_ack) w_st_next = S_RESPOND;
         default:   w_st_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_n_i) begin
         r_ld_ddr      <= 1'b0;
         r_ld_slot     <= '0;
         r_ld_word     <= '0;
         r_ld_data     <= '0;
         r_ddr_ld_addr <= '0;
         r_ddr_ld_req  <= 1'b0;
         r_ddr_ld_inv  <= 1'b0;
         r_rd_req      <= '0;
      end else begin
         r_ddr_ld_req <= 1'b0;
         r_ddr_ld_inv <= w_ld_cancel && r_ld_ddr;
         r_rd_req     <= '0;
         if (w_ld_accept) begin
            r_ld_ddr      <= !w_ld_io;
            r_ld_slot     <= w_ld_slot;
            r_ld_word     <= cpu_load_address_i[7:2];
            r_ddr_ld_addr <= cpu_load_address_i;
            r_ld_data     <= '0;
            if (!w_ld_io)         r_ddr_ld_req <= 1'b1;
            else if (w_ld_slot_ok) r_rd_req    <= DEVICES'(1) << w_ld_slot;
         end
         if ((r_ld_state == S_PENDING) && !cpu_load_invalidate_i && w_ld_ack)
            r_ld_data <= r_ld_ddr ? ddr_load_data_i : w_ld_io_data;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_n_i) begin
         r_st_ddr      <= 1'b0;
         r_st_slot     <= '0;
         r_st_word     <= '0;
         r_st_data     <= '0;
         r_ddr_st_addr <= '0;
         r_ddr_st_req  <= 1'b0;
         r_wr_req      <= '0;
      end else begin
         r_ddr_st_req <= 1'b0;
         r_wr_req     <= '0;
         if (w_st_accept) begin
            r_st_ddr      <= !w_st_io;
            r_st_slot     <= w_st_slot;
            r_st_word     <= cpu_store_address_i[7:2];
            r_st_data     <= cpu_store_data_i;
            r_ddr_st_addr <= cpu_store_address_i;
            if (!w_st_io)         r_ddr_st_req <= 1'b1;
            else if (w_st_slot_ok) r_wr_req    <= DEVICES'(1) << w_st_slot;
         end
      end
   end

   always_comb begin
      write_address_o = '0;
      write_data_o    = '0;
      read_address_o  = '0;
      for (int d = 0; d < DEVICES; d++) begin
         write_address_o[d] = r_st_word;
         write_data_o[d]    = r_st_data;
         read_address_o[d]  = r_ld_word;
      end
   end

   assign locked_o              = r_locked;
   assign cpu_load_valid_o      = (r_ld_state == S_RESPOND);
   assign cpu_load_data_o       = r_ld_data;
   assign cpu_store_done_o      = (r_st_state == S_RESPOND);
   assign ddr_load_request_o    = r_ddr_ld_req;
   assign ddr_load_address_o    = r_ddr_ld_addr;
   assign ddr_load_invalidate_o = r_ddr_ld_inv;
   assign ddr_store_request_o   = r_ddr_st_req;
   assign ddr_store_address_o   = r_ddr_st_addr;
   assign ddr_store_data_o      = r_st_data;
   assign write_request_o       = r_wr_req;
   assign read_request_o        = r_rd_req;

endmodule

// File: tb/tb_zenith_soc.sv
// Scoreboard bench for zenith_soc: stimulus pushes timed expected events,
// a monitor matches every DUT output pulse against them.
module tb_zenith_soc;
   localparam int DEVICES = 3;
   localparam int K_LDV = 0, K_STD = 1, K_RD = 2, K_WR = 3, K_DLD = 4, K_DST = 5, K_DINV = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     rst_n_i, locked_o;
   logic                     cpu_load_request_i, cpu_load_invalidate_i, cpu_load_valid_o;
   logic [31:0]              cpu_load_address_i, cpu_load_data_o;
   logic                     cpu_store_request_i, cpu_store_done_o;
   logic [31:0]              cpu_store_address_i, cpu_store_data_i;
   logic                     ddr_load_request_o, ddr_load_invalidate_o, ddr_load_valid_i;
   logic [31:0]              ddr_load_address_o, ddr_load_data_i;
   logic                     ddr_store_request_o, ddr_store_done_i;
   logic [31:0]              ddr_store_address_o, ddr_store_data_o;
   logic [DEVICES-1:0]       write_request_o, write_done_i, read_request_o, read_valid_i;
   logic [DEVICES-1:0][5:0]  write_address_o, read_address_o;
   logic [DEVICES-1:0][31:0] write_data_o, read_data_i;

   zenith_soc dut (
      .clk_i(clk), .rst_n_i(rst_n_i), .locked_o(locked_o),
      .cpu_load_request_i(cpu_load_request_i), .cpu_load_address_i(cpu_load_address_i),
      .cpu_load_invalidate_i(cpu_load_invalidate_i), .cpu_load_data_o(cpu_load_data_o),
      .cpu_load_valid_o(cpu_load_valid_o), .cpu_store_request_i(cpu_store_request_i),
      .cpu_store_address_i(cpu_store_address_i), .cpu_store_data_i(cpu_store_data_i),
      .cpu_store_done_o(cpu_store_done_o), .ddr_load_request_o(ddr_load_request_o),
      .ddr_load_address_o(ddr_load_address_o), .ddr_load_invalidate_o(ddr_load_invalidate_o),
      .ddr_load_data_i(ddr_load_data_i), .ddr_load_valid_i(ddr_load_valid_i),
      .ddr_store_request_o(ddr_store_request_o), .ddr_store_address_o(ddr_store_address_o),
      .ddr_store_data_o(ddr_store_data_o), .ddr_store_done_i(ddr_store_done_i),
      .write_request_o(write_request_o), .write_address_o(write_address_o),
      .write_data_o(write_data_o), .write_done_i(write_done_i),
      .read_request_o(read_request_o), .read_address_o(read_address_o),
      .read_data_i(read_data_i), .read_valid_i(read_valid_i)
   );

   int checks = 0, errors = 0, cyc = 0;

   typedef struct {
      int          cyc;
      int          kind;
      int          slot;
      logic [31:0] a;
      logic [31:0] d;
   } ev_t;
   ev_t exp_q[$];

   logic any_out;
   assign any_out = locked_o | cpu_load_valid_o | (|cpu_load_data_o) | cpu_store_done_o |
                    ddr_load_request_o | (|ddr_load_address_o) | ddr_load_invalidate_o |
                    ddr_store_request_o | (|ddr_store_address_o) | (|ddr_store_data_o) |
                    (|write_request_o) | (|write_address_o) | (|write_data_o) |
                    (|read_request_o) | (|read_address_o);

   function automatic string kname(int k);
      case (k)
         K_LDV:   return "load_valid";
         K_STD:   return "store_done";
         K_RD:    return "dev_read_req";
         K_WR:    return "dev_write_req";
         K_DLD:   return "ddr_load_req";
         K_DST:   return "ddr_store_req";
         default: return "ddr_load_inv";
      endcase
   endfunction

   task automatic chk(string name, logic [31:0] got, logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   // Expected event lands on the edge that samples the current drive
   task automatic expect_ev(int k, int s, logic [31:0] a, logic [31:0] d);
      ev_t e;
      e.cyc = cyc + 1; e.kind = k; e.slot = s; e.a = a; e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic observe(int k, int s, logic [31:0] a, logic [31:0] d);
      int idx;
      idx = -1;
      for (int i = 0; i < exp_q.size(); i++)
         if (idx < 0 && exp_q[i].kind == k && exp_q[i].slot == s) idx = i;
      checks++;
      if (idx < 0) begin
         errors++;
         $display("FAIL %s slot %0d: got unexpected pulse a=%h d=%h at cycle %0d, required none",
                  kname(k), s, a, d, cyc);
      end else begin
         if (exp_q[idx].cyc != cyc || exp_q[idx].a !== a || exp_q[idx].d !== d) begin
            errors++;
            $display("FAIL %s slot %0d: got cycle %0d a=%h d=%h, required cycle %0d a=%h d=%h",
                     kname(k), s, cyc, a, d, exp_q[idx].cyc, exp_q[idx].a, exp_q[idx].d);
         end
         exp_q.delete(idx);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (cpu_load_valid_o)      observe(K_LDV, 0, 32'h0, cpu_load_data_o);
         if (cpu_store_done_o)      observe(K_STD, 0, 32'h0, 32'h0);
         if (ddr_load_request_o)    observe(K_DLD, 0, ddr_load_address_o, 32'h0);
         if (ddr_store_request_o)   observe(K_DST, 0, ddr_store_address_o, ddr_store_data_o);
         if (ddr_load_invalidate_o) observe(K_DINV, 0, 32'h0, 32'h0);
         for (int d = 0; d < DEVICES; d++) begin
            if (write_request_o[d]) observe(K_WR, d, {26'h0, write_address_o[d]}, write_data_o[d]);
            if (read_request_o[d])  observe(K_RD, d, {26'h0, read_address_o[d]}, 32'h0);
         end
         for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc < cyc) begin
               checks++;
               errors++;
               $display("FAIL %s slot %0d: got no pulse by cycle %0d, required at cycle %0d",
                        kname(exp_q[i].kind), exp_q[i].slot, cyc, exp_q[i].cyc);
               exp_q.delete(i);
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      cpu_load_request_i    = 1'b0;
      cpu_store_request_i   = 1'b0;
      cpu_load_invalidate_i = 1'b0;
      ddr_load_valid_i      = 1'b0;
      ddr_store_done_i      = 1'b0;
      write_done_i          = '0;
      read_valid_i          = '0;
   endtask

   initial begin
      rst_n_i = 1'b1;
      cpu_load_request_i = 0; cpu_load_address_i = 0; cpu_load_invalidate_i = 0;
      cpu_store_request_i = 0; cpu_store_address_i = 0; cpu_store_data_i = 0;
      ddr_load_data_i = 0; ddr_load_valid_i = 0; ddr_store_done_i = 0;
      write_done_i = '0; read_data_i = '0; read_valid_i = '0;

      repeat (39) @(negedge clk);
      chk("reset_outputs_zero", {31'h0, any_out}, 32'h0);
      @(negedge clk);
      rst_n_i = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("locked_edge%0d", k), {31'h0, locked_o}, (k == 16) ? 32'h1 : 32'h0);
         if (k == 5) begin
            cpu_load_request_i = 1'b1;
            cpu_load_address_i = 32'h0010_0000;
         end
         if (k == 6) cpu_load_request_i = 1'b0;
      end
      step();

      // IO store with a non-addressed ack first
      cpu_store_request_i = 1; cpu_store_address_i = 32'h0000_0104; cpu_store_data_i = 32'h41;
      expect_ev(K_WR, 1, 32'h1, 32'h41);
      step(); step();
      write_done_i = 3'b001;
      step();
      write_done_i = 3'b010;
      expect_ev(K_STD, 0, 0, 0);
      step(); step();

      // DDR load
      cpu_load_request_i = 1; cpu_load_address_i = 32'h0010_0040;
      expect_ev(K_DLD, 0, 32'h0010_0040, 0);
      step(); step();
      ddr_load_valid_i = 1; ddr_load_data_i = 32'hDEAD_BEEF;
      expect_ev(K_LDV, 0, 0, 32'hDEAD_BEEF);
      step(); step();

      // DDR load cancelled in the same cycle as its response
      cpu_load_request_i = 1; cpu_load_address_i = 32'h0020_0000;
      expect_ev(K_DLD, 0, 32'h0020_0000, 0);
      step(); step();
      ddr_load_valid_i = 1; ddr_load_data_i = 32'h1234_5678; cpu_load_invalidate_i = 1;
      expect_ev(K_DINV, 0, 0, 0);
      step(); step(); step();

      // Out-of-range slot 31: simultaneous load and store
      cpu_load_request_i = 1;  cpu_load_address_i = 32'h0000_1F00;
      cpu_store_request_i = 1; cpu_store_address_i = 32'h0000_1F04; cpu_store_data_i = 32'h99;
      expect_ev(K_LDV, 0, 0, 32'h0);
      expect_ev(K_STD, 0, 0, 0);
      step(); step();

      // Second load while pending is ignored; response from wrong slot ignored
      cpu_load_request_i = 1; cpu_load_address_i = 32'h0000_0208;
      expect_ev(K_RD, 2, 32'h2, 0);
      step();
      cpu_load_request_i = 1; cpu_load_address_i = 32'h0000_0004;
      step();
      read_valid_i = 3'b001; read_data_i[0] = 32'h55;
      step();
      read_valid_i = 3'b100; read_data_i[2] = 32'h1234_5678;
      expect_ev(K_LDV, 0, 0, 32'h1234_5678);
      step(); step();

      // Load and store to the same slot, acked together; store ignores addr[1:0]
      cpu_load_request_i = 1;  cpu_load_address_i = 32'h0000_000C;
      cpu_store_request_i = 1; cpu_store_address_i = 32'h0000_0013; cpu_store_data_i = 32'hA5A5_0001;
      expect_ev(K_RD, 0, 32'h3, 0);
      expect_ev(K_WR, 0, 32'h4, 32'hA5A5_0001);
      step(); step();
      write_done_i = 3'b001; read_valid_i = 3'b001; read_data_i[0] = 32'hCAFE_F00D;
      expect_ev(K_STD, 0, 0, 0);
      expect_ev(K_LDV, 0, 0, 32'hCAFE_F00D);
      step(); step();

      // DDR store
      cpu_store_request_i = 1; cpu_store_address_i = 32'h0040_0000; cpu_store_data_i = 32'h1122_3344;
      expect_ev(K_DST, 0, 32'h0040_0000, 32'h1122_3344);
      step(); step();
      ddr_store_done_i = 1;
      expect_ev(K_STD, 0, 0, 0);
      step(); step();

      // Idle invalidate, then cancelled IO load (no DDR invalidate), late ack ignored
      cpu_load_invalidate_i = 1;
      step();
      cpu_load_request_i = 1; cpu_load_address_i = 32'h0000_0100;
      expect_ev(K_RD, 1, 32'h0, 0);
      step();
      cpu_load_invalidate_i = 1;
      step();
      read_valid_i = 3'b010;
      step(); step();

      // Upper IO address bits ignored: 0x000FE107 -> slot 1, word 1
      cpu_store_request_i = 1; cpu_store_address_i = 32'h000F_E107; cpu_store_data_i = 32'h77;
      expect_ev(K_WR, 1, 32'h1, 32'h77);
      step(); step();
      write_done_i = 3'b010;
      expect_ev(K_STD, 0, 0, 0);
      step(); step();

      // Reset during a pending DDR store; late ack after reset ignored
      cpu_store_request_i = 1; cpu_store_address_i = 32'h0050_0000; cpu_store_data_i = 32'hAB;
      expect_ev(K_DST, 0, 32'h0050_0000, 32'hAB);
      step(); step();
      rst_n_i = 1'b1;
      step(); step();
      chk("midreset_outputs_zero", {31'h0, any_out}, 32'h0);
      rst_n_i = 1'b0;
      ddr_store_done_i = 1;
      step();
      repeat (16) step();
      chk("relocked", {31'h0, locked_o}, 32'h1);

      // Region boundary: last IO word decodes to slot 31, first DDR address goes to DDR
      cpu_load_request_i = 1; cpu_load_address_i = 32'h000F_FFFC;
      expect_ev(K_LDV, 0, 0, 32'h0);
      step(); step();
      cpu_load_request_i = 1; cpu_load_address_i = 32'h0010_0000;
      expect_ev(K_DLD, 0, 32'h0010_0000, 0);
      step(); step();
      ddr_load_valid_i = 1; ddr_load_data_i = 32'h0BAD_F00D;
      expect_ev(K_LDV, 0, 0, 32'h0BAD_F00D);
      step();

      repeat (4) step();
      chk("scoreboard_empty", exp_q.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
